scm_rr_arbiter: RTL and testbench
=================================

Name: scm_rr_arbiter

Overview:
- Shares one two-port standard-cell memory (independent write port WE/WADDR/DIN and read port RE/RADDR/DOUT) between two requesters.
- Arbitrates writes and reads separately, each with its own round-robin pointer, so one write and one read can issue per cycle.
- Masks a read that collides with the same-cycle write address.
- Returns read data to the owning requester after the SCM read latency.

Parameters:
- ADDR_WIDTH, 7, SCM address width.
- DATA_WIDTH, 32, SCM data width.
- RD_LAT, 1, cycles from the clk edge sampling scm_re to valid scm_dout; legal range 1..4.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_req0, wr_req1  in  1  write request; held until granted.
- wr_addr0, wr_addr1  in  ADDR_WIDTH  write address.
- wr_data0, wr_data1  in  DATA_WIDTH  write data.
- wr_gnt0, wr_gnt1  out  1  write accepted this cycle (combinational).
- rd_req0, rd_req1  in  1  read request; held until granted.
- rd_addr0, rd_addr1  in  ADDR_WIDTH  read address.
- rd_gnt0, rd_gnt1  out  1  read accepted this cycle (combinational).
- rd_vld0, rd_vld1  out  1  read data valid for that requester.
- rd_data  out  DATA_WIDTH  returned read data, shared by both requesters.
- scm_we  out  1  SCM write enable.
- scm_waddr  out  ADDR_WIDTH  SCM write address.
- scm_din  out  DATA_WIDTH  SCM write data.
- scm_re  out  1  SCM read enable.
- scm_raddr  out  ADDR_WIDTH  SCM read address.
- scm_dout  in  DATA_WIDTH  SCM read data.

Behaviour:
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, tag pipeline cleared.
  - All gnt, vld and scm_we/scm_re outputs forced to 0 while rst=1.
  - scm_waddr, scm_raddr, scm_din, rd_data are 0 while rst=1.
- Write arbitration (combinational):
  - Only one wr_reqi high: grant i.
  - Both high: grant wr_ptr.
  - On the clock edge after any write grant, wr_ptr <= index of the other requester. No grant leaves wr_ptr unchanged.
  - scm_we = wr_gnt0 | wr_gnt1. scm_waddr/scm_din are muxed from the granted requester; 0 when idle.
- Read eligibility: rd_reqi is eligible unless scm_we=1 and rd_addri == scm_waddr in the same cycle (hazard mask).
  - A masked request stays pending and is granted in a later cycle, so it returns the newly written data.
- Read arbitration: same round-robin rule as writes, over eligible requests, using rd_ptr.
  - rd_ptr updates only on a read grant.
  - scm_re = rd_gnt0 | rd_gnt1. scm_raddr is muxed from the granted requester.
- Return path:
  - A RD_LAT-deep shift register carries {valid, requester id}, loaded on each read grant.
  - At stage RD_LAT, rd_vld{id}=1 and rd_data=scm_dout; otherwise rd_vld0=rd_vld1=0 and rd_data=0.
  - A read granted in cycle t yields rd_vld in cycle t+RD_LAT.
  - Back-to-back reads stream one result per cycle.
- A requester may change its address/data only after its gnt has been sampled high.
- Deasserting a request before grant withdraws it; no state is kept.
- Simultaneous write and read to different addresses: both granted in the same cycle.
- Reset mid-operation drops all in-flight reads; no rd_vld follows reset release for reads granted before reset.
- Latency: grant is zero-cycle, combinational from requests and pointers. No combinational path from scm_dout to any grant.

Test Plan:
1. Reset: rst=1 with all reqs high -> all gnt/vld/scm_we/scm_re = 0. After release, wr_ptr=0, so both writes high -> wr_gnt0=1 first cycle, wr_gnt1=1 second cycle.
2. Round-robin fairness: both rd_req held for 6 cycles, RD_LAT=1 -> grants alternate 0,1,0,1,0,1; rd_vld alternates one cycle later with matching data.
3. Write then read: req0 writes 0xDEADBEEF to addr 5 in cycle 0; req1 reads addr 5 in cycle 1 -> rd_vld1=1 in cycle 2, rd_data=0xDEADBEEF.
4. Hazard: in the same cycle, req0 writes addr 9 = 0x12345678 and req1 reads addr 9 -> rd_gnt1=0 that cycle, rd_gnt1=1 next cycle, returned data 0x12345678. A concurrent read of addr 3 is granted unaffected.
5. Parallel ports: write addr 2 and read addr 7 in the same cycle -> scm_we=1 and scm_re=1 together, both gnts high.
6. Reset mid-flight: RD_LAT=3, read granted in cycle t, rst pulses in t+1 -> no rd_vld in t+3; outputs 0 during reset.

Source files
------------

// File: rtl/scm_rr_arbiter_if.sv
// Bundle of requester handshakes and SCM port signals for the two-port SCM arbiter.
// slave: arbiter side. master: requesters plus the SCM macro.
interface scm_rr_arbiter_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic                  wr_req0, wr_req1;
  logic [ADDR_WIDTH-1:0] wr_addr0, wr_addr1;
  logic [DATA_WIDTH-1:0] wr_data0, wr_data1;
  logic                  wr_gnt0, wr_gnt1;
  logic                  rd_req0, rd_req1;
  logic [ADDR_WIDTH-1:0] rd_addr0, rd_addr1;
  logic                  rd_gnt0, rd_gnt1;
  logic                  rd_vld0, rd_vld1;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  scm_we;
  logic [ADDR_WIDTH-1:0] scm_waddr;
  logic [DATA_WIDTH-1:0] scm_din;
  logic                  scm_re;
  logic [ADDR_WIDTH-1:0] scm_raddr;
  logic [DATA_WIDTH-1:0] scm_dout;

  modport slave (
    input  wr_req0, wr_req1, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  rd_req0, rd_req1, rd_addr0, rd_addr1, scm_dout,
    output wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1, rd_vld0, rd_vld1, rd_data,
    output scm_we, scm_waddr, scm_din, scm_re, scm_raddr
  );

  modport master (
    output wr_req0, wr_req1, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output rd_req0, rd_req1, rd_addr0, rd_addr1, scm_dout,
    input  wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1, rd_vld0, rd_vld1, rd_data,
    input  scm_we, scm_waddr, scm_din, scm_re, scm_raddr
  );
endinterface

// File: rtl/scm_rr_arbiter.sv
// Two-requester round-robin arbiter for a two-port SCM: independent write and
// read arbitration, read-after-write hazard masking, tagged read return path.
module scm_rr_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input logic              clk,
  input logic              rst,
  scm_rr_arbiter_if.slave  bus
);

  logic                  wr_ptr, rd_ptr;
  logic                  wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
  logic                  we, re, elig0, elig1;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [DATA_WIDTH-1:0] din;
  logic [RD_LAT-1:0]     vld_sr, id_sr;
  logic                  out_vld, out_id;

  // Write round-robin: a lone request wins, a tie goes to wr_ptr.
  always_comb begin
    wr_gnt0 = 1'b0;
    wr_gnt1 = 1'b0;
    if (!rst) begin
      wr_gnt0 = bus.wr_req0 && (!bus.wr_req1 || !wr_ptr);
      wr_gnt1 = bus.wr_req1 && (!bus.wr_req0 ||  wr_ptr);
    end
  end

  // Write port mux from the granted requester, zero when idle.
  always_comb begin
    we    = wr_gnt0 | wr_gnt1;
    waddr = '0;
    din   = '0;
    if (wr_gnt1) begin
      waddr = bus.wr_addr1;
      din   = bus.wr_data1;
    end else if (wr_gnt0) begin
      waddr = bus.wr_addr0;
      din   = bus.wr_data0;
    end
  end

  // A read that hits the address being written this cycle waits a cycle.
  always_comb begin
    elig0 = bus.rd_req0 && !(we && (bus.rd_addr0 == waddr));
    elig1 = bus.rd_req1 && !(we && (bus.rd_addr1 == waddr));
  end

  // Read round-robin over eligible requests, then read port mux.
  always_comb begin
    rd_gnt0 = 1'b0;
    rd_gnt1 = 1'b0;
    raddr   = '0;
    if (!rst) begin
      rd_gnt0 = elig0 && (!elig1 || !rd_ptr);
      rd_gnt1 = elig1 && (!elig0 ||  rd_ptr);
    end
    if (rd_gnt1)      raddr = bus.rd_addr1;
    else if (rd_gnt0) raddr = bus.rd_addr0;
    re = rd_gnt0 | rd_gnt1;
  end

  // Pointers move to the other requester after a grant; granting 0 means
  // next priority is 1, so the new pointer value equals gnt0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (we) wr_ptr <= wr_gnt0;
      if (re) rd_ptr <= rd_gnt0;
    end
  end

  // Return-path tag pipeline: {valid, requester id} follows the SCM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
      id_sr  <= '0;
    end else begin
      vld_sr[0] <= re;
      id_sr[0]  <= rd_gnt1;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        id_sr[i]  <= id_sr[i-1];
      end
    end
  end

  assign out_vld = vld_sr[RD_LAT-1] & ~rst;
  assign out_id  = id_sr[RD_LAT-1];

  assign bus.wr_gnt0   = wr_gnt0;
  assign bus.wr_gnt1   = wr_gnt1;
  assign bus.rd_gnt0   = rd_gnt0;
  assign bus.rd_gnt1   = rd_gnt1;
  assign bus.scm_we    = we;
  assign bus.scm_waddr = waddr;
  assign bus.scm_din   = din;
  assign bus.scm_re    = re;
  assign bus.scm_raddr = raddr;
  assign bus.rd_vld0   = out_vld & ~out_id;
  assign bus.rd_vld1   = out_vld &  out_id;
  assign bus.rd_data   = out_vld ? bus.scm_dout : '0;

endmodule

// File: tb/tb_scm_rr_arbiter.sv
// Randomized + directed bench for scm_rr_arbiter with a behavioural reference
// model and a scoreboard for the read return path.
module tb_scm_rr_arbiter;
  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scm_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  scm_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          id;
    logic [DW-1:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  // grants predicted by the model in the last sampled cycle (driver feedback)
  logic g_w0 = 1'b0, g_w1 = 1'b0, g_r0 = 1'b0, g_r1 = 1'b0;

  function automatic logic [DW-1:0] init_val(int i);
    return 32'h9E37_79B9 * i + 32'h0000_1234;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SCM behavioural model: write port, read port with LAT-cycle latency
  logic [DW-1:0] scm_mem [DEPTH];
  logic [DW-1:0] rpipe [LAT];
  assign bus.scm_dout = rpipe[LAT-1];
  initial begin
    for (int i = 0; i < DEPTH; i++) scm_mem[i] = init_val(i);
    for (int i = 0; i < LAT; i++) rpipe[i] = '0;
    forever begin
      @(posedge clk);
      if (bus.scm_we) scm_mem[bus.scm_waddr] <= bus.scm_din;
      if (bus.scm_re) rpipe[0] <= scm_mem[bus.scm_raddr];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
  end

  // Reference model: predicts grants and SCM port values from the request
  // rules, tracks memory contents, pushes expected read returns.
  initial begin
    logic [DW-1:0] ref_mem [DEPTH];
    int  wp, rp;
    bit  ew0, ew1, er0, er1, e0, e1, wact;
    logic [AW-1:0] ewa, era;
    logic [DW-1:0] ewd;
    exp_t it;
    wp = 0; rp = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        wp = 0; rp = 0;
        q.delete();
        g_w0 = 0; g_w1 = 0; g_r0 = 0; g_r1 = 0;
        chk("reset_ctrl", {bus.wr_gnt0, bus.wr_gnt1, bus.rd_gnt0, bus.rd_gnt1,
                           bus.scm_we, bus.scm_re, bus.rd_vld0, bus.rd_vld1}, 64'd0);
        chk("reset_waddr", bus.scm_waddr, 64'd0);
        chk("reset_raddr", bus.scm_raddr, 64'd0);
        chk("reset_din", bus.scm_din, 64'd0);
        chk("reset_rdata", bus.rd_data, 64'd0);
      end else begin
        ew0 = 0; ew1 = 0;
        if (bus.wr_req0 && bus.wr_req1) begin
          if (wp == 0) ew0 = 1; else ew1 = 1;
        end else if (bus.wr_req0) ew0 = 1;
        else if (bus.wr_req1) ew1 = 1;
        wact = ew0 || ew1;
        ewa  = ew0 ? bus.wr_addr0 : (ew1 ? bus.wr_addr1 : '0);
        ewd  = ew0 ? bus.wr_data0 : (ew1 ? bus.wr_data1 : '0);

        e0 = bus.rd_req0 && !(wact && bus.rd_addr0 == ewa);
        e1 = bus.rd_req1 && !(wact && bus.rd_addr1 == ewa);
        er0 = 0; er1 = 0;
        if (e0 && e1) begin
          if (rp == 0) er0 = 1; else er1 = 1;
        end else if (e0) er0 = 1;
        else if (e1) er1 = 1;
        era = er0 ? bus.rd_addr0 : bus.rd_addr1;

        chk("grants", {bus.wr_gnt0, bus.wr_gnt1, bus.rd_gnt0, bus.rd_gnt1,
                       bus.scm_we, bus.scm_re},
            {ew0, ew1, er0, er1, wact, er0 || er1});
        chk("scm_waddr", bus.scm_waddr, ewa);
        chk("scm_din", bus.scm_din, ewd);
        if (er0 || er1) begin
          chk("scm_raddr", bus.scm_raddr, era);
          it.id = er1 ? 1 : 0;
          it.data = ref_mem[era];
          it.due = cyc + LAT;
          q.push_back(it);
        end
        if (wact) ref_mem[ewa] = ewd;
        if (ew0) wp = 1; else if (ew1) wp = 0;
        if (er0) rp = 1; else if (er1) rp = 0;
        g_w0 = ew0; g_w1 = ew1; g_r0 = er0; g_r1 = er1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rd_vld0 || bus.rd_vld1) begin
          if (q.size() == 0) begin
            chk("unexpected_vld", {bus.rd_vld0, bus.rd_vld1}, 64'd0);
          end else begin
            it = q.pop_front();
            chk("rd_vld_id", {bus.rd_vld0, bus.rd_vld1}, (it.id == 1) ? 64'd1 : 64'd2);
            chk("rd_data", bus.rd_data, it.data);
            chk("rd_latency", cyc, it.due);
          end
        end else begin
          chk("rd_data_idle", bus.rd_data, 64'd0);
          if (q.size() > 0 && q[0].due <= cyc) begin
            it = q.pop_front();
            chk("missing_vld", 64'd0, 64'd1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.wr_req0 = 0; bus.wr_req1 = 0; bus.rd_req0 = 0; bus.rd_req1 = 0;
  endtask

  // Random requesters: hold until granted, occasionally withdraw.
  task automatic rand_cycle();
    if (!bus.wr_req0 || g_w0) begin
      bus.wr_req0 = ($urandom_range(0, 2) != 0);
      bus.wr_addr0 = AW'($urandom_range(0, 15));
      bus.wr_data0 = $urandom;
    end else if ($urandom_range(0, 15) == 0) bus.wr_req0 = 0;
    if (!bus.wr_req1 || g_w1) begin
      bus.wr_req1 = ($urandom_range(0, 2) != 0);
      bus.wr_addr1 = AW'($urandom_range(0, 15));
      bus.wr_data1 = $urandom;
    end else if ($urandom_range(0, 15) == 0) bus.wr_req1 = 0;
    if (!bus.rd_req0 || g_r0) begin
      bus.rd_req0 = ($urandom_range(0, 2) != 0);
      bus.rd_addr0 = AW'($urandom_range(0, 15));
    end else if ($urandom_range(0, 15) == 0) bus.rd_req0 = 0;
    if (!bus.rd_req1 || g_r1) begin
      bus.rd_req1 = ($urandom_range(0, 2) != 0);
      bus.rd_addr1 = AW'($urandom_range(0, 15));
    end else if ($urandom_range(0, 15) == 0) bus.rd_req1 = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.wr_addr0 = 7'd10; bus.wr_addr1 = 7'd11;
    bus.wr_data0 = 32'hA0A0_0000; bus.wr_data1 = 32'hB1B1_0001;
    bus.rd_addr0 = 7'd20; bus.rd_addr1 = 7'd21;
    // all requests high while in reset
    bus.wr_req0 = 1; bus.wr_req1 = 1; bus.rd_req0 = 1; bus.rd_req1 = 1;
    repeat (3) tick();
    // release: both writes pending, port 0 wins first, then port 1
    bus.rd_req0 = 0; bus.rd_req1 = 0;
    rst = 1'b0;
    tick();
    bus.wr_req0 = 0;
    tick();
    idle_all();
    tick();

    // round-robin reads held for six cycles
    bus.rd_addr0 = 7'd1; bus.rd_addr1 = 7'd2;
    bus.rd_req0 = 1; bus.rd_req1 = 1;
    repeat (6) tick();
    idle_all();
    repeat (LAT + 1) tick();

    // write then read of the same address
    bus.wr_req0 = 1; bus.wr_addr0 = 7'd5; bus.wr_data0 = 32'hDEAD_BEEF;
    tick();
    idle_all();
    bus.rd_req1 = 1; bus.rd_addr1 = 7'd5;
    tick();
    idle_all();
    repeat (LAT + 1) tick();

    // hazard: same-cycle write/read of addr 9, concurrent read of addr 3
    bus.wr_req0 = 1; bus.wr_addr0 = 7'd9; bus.wr_data0 = 32'h1234_5678;
    bus.rd_req1 = 1; bus.rd_addr1 = 7'd9;
    bus.rd_req0 = 1; bus.rd_addr0 = 7'd3;
    tick();
    bus.wr_req0 = 0; bus.rd_req0 = 0;
    tick();
    idle_all();
    repeat (LAT + 1) tick();

    // parallel ports: write addr 2 and read addr 7 together
    bus.wr_req1 = 1; bus.wr_addr1 = 7'd2; bus.wr_data1 = 32'hCAFE_0002;
    bus.rd_req0 = 1; bus.rd_addr0 = 7'd7;
    tick();
    idle_all();
    repeat (LAT + 1) tick();

    // reset one cycle after a read grant drops the in-flight return
    bus.rd_req0 = 1; bus.rd_addr0 = 7'd4;
    tick();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (LAT + 3) tick();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rand_cycle();
      tick();
    end
    idle_all();

    // bounded drain of outstanding reads
    for (int i = 0; i < LAT + 10 && q.size() > 0; i++) tick();
    tick();
    chk("drain_empty", q.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
